// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
// Serial frame receiver: start bit (0), DATA_W data bits LSB first, one parity
// bit, one stop bit (1). The received word and its error flags are held on a
// valid/ready output until the consumer accepts them. Reception never stalls:
// a frame that completes while an unaccepted word is still held is dropped,
// and overrun pulses for one cycle.
//
// Parameters:
//   DATA_W       data bits per frame (4..16)
//   CLKS_PER_BIT clock cycles per serial bit (even, >= 4)
//   ODD_PARITY   0 = even parity, 1 = odd parity
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx           serial line, idle high, asynchronous to clk
//   out_data     received word
//   out_valid    out_data / flags valid
//   out_ready    consumer accepts when out_valid && out_ready
//   out_par_err  parity check failed for the held word
//   out_frm_err  stop bit sampled low for the held word
//   overrun      one-cycle pulse, a completed frame was dropped
//   err_cnt      (only with PARITY_ERR_CNT_EN) saturating count of loaded
//                words carrying a parity or framing error
//
// Optional feature macro: PARITY_ERR_CNT_EN
// -----------------------------------------------------------------------------
module parity_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par_err,
    output logic              out_frm_err,
    output logic              overrun
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_nxt;
    logic              rx_meta, rx_s, rx_s_q;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              par_bit, par_bit_nxt;
    logic              done, done_nxt;
    logic              done_perr, done_perr_nxt;
    logic              done_ferr, done_ferr_nxt;
    logic              tick;

    // Synchronizer plus one extra flop for falling-edge detection; all
    // three idle high so reset release cannot look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_q  <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            done      <= 1'b0;
            done_perr <= 1'b0;
            done_ferr <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            par_bit   <= par_bit_nxt;
            done      <= done_nxt;
            done_perr <= done_perr_nxt;
            done_ferr <= done_ferr_nxt;
        end
    end

    assign tick = (cnt == '0);

    // The half-bit load on the start edge places every later sample point
    // near the middle of its bit.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        par_bit_nxt   = par_bit;
        done_nxt      = 1'b0;
        done_perr_nxt = done_perr;
        done_ferr_nxt = done_ferr;
        case (state)
            IDLE: begin
                if (rx_s_q && !rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = CNT_HALF;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        cnt_nxt     = CNT_FULL;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = {rx_s, shift[DATA_W-1:1]};
                    cnt_nxt   = CNT_FULL;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = PARITY;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            PARITY: begin
                if (tick) begin
                    par_bit_nxt = rx_s;
                    state_nxt   = STOP;
                    cnt_nxt     = CNT_FULL;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt     = IDLE;
                    done_nxt      = 1'b1;
                    done_perr_nxt = (^shift) ^ par_bit ^ ODD_BIT;
                    done_ferr_nxt = !rx_s;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A completion can only be loaded if the output is empty or being
    // accepted this very cycle; otherwise the new frame is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_par_err <= 1'b0;
            out_frm_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    out_data    <= shift;
                    out_par_err <= done_perr;
                    out_frm_err <= done_ferr;
                    out_valid   <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (done && !(out_valid && !out_ready) &&
                     (done_perr || done_ferr) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam logic ODD = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_par_err;
    logic          out_frm_err;
    logic          overrun;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    int ovr_pulses = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];

    parity_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_par_err(out_par_err),
        .out_frm_err(out_frm_err),
        .overrun    (overrun)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (out_valid) valid_cycles++;
        if (overrun) ovr_pulses++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word: observed %h expected none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 16'(out_data), 16'(e.d));
                chk("out_par_err", 16'(out_par_err), 16'(e.pe));
                chk("out_frm_err", 16'(out_frm_err), 16'(e.fe));
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit push);
        if (push) begin
            exp_t e;
            e.d  = d;
            e.pe = (^d) ^ p ^ ODD;
            e.fe = ~s;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 16'(sb.size()), 16'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_data"}, 16'(out_data), 16'd0);
        chk({tag, "_par"}, 16'(out_par_err), 16'd0);
        chk({tag, "_frm"}, 16'(out_frm_err), 16'd0);
        chk({tag, "_ovr"}, 16'(overrun), 16'd0);
`ifdef PARITY_ERR_CNT_EN
        chk({tag, "_errcnt"}, 16'(err_cnt), 16'd0);
`endif
    endtask

    initial begin
        int v0;
        int o0;

        // Reset state
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Clean frame, consumer always ready: exactly one valid cycle
        out_ready = 1'b1;
        v0 = valid_cycles;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_a5");
        chk("a5_valid_cycles", 16'(valid_cycles - v0), 16'd1);

        // False start: one low cycle, no output expected
        v0 = valid_cycles;
        @(posedge clk);
        #1;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("false_start_valid", 16'(valid_cycles - v0), 16'd0);

        // Parity error
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_01");
`ifdef PARITY_ERR_CNT_EN
        chk("errcnt_after_01", 16'(err_cnt), 16'd1);
`endif

        // Framing error
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_3c");
`ifdef PARITY_ERR_CNT_EN
        chk("errcnt_after_3c", 16'(err_cnt), 16'd2);
`endif

        // Backpressure: second frame dropped, one overrun pulse
        out_ready = 1'b0;
        o0 = ovr_pulses;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        chk("ovr_held_valid", 16'(out_valid), 16'd1);
        chk("ovr_held_data", 16'(out_data), 16'h0011);
        chk("ovr_pulses", 16'(ovr_pulses - o0), 16'd1);
        out_ready = 1'b1;
        wait_drain("drain_11");
        repeat (10) @(posedge clk);
        #1;
        chk("ovr_no_22_valid", 16'(out_valid), 16'd0);

        // Hold a word, then reset during data bit 3 of a following frame
        out_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        #1;
        chk("pre_reset_valid", 16'(out_valid), 16'd1);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6 * CPB) @(posedge clk);
        #1;
        chk("post_reset_valid", 16'(out_valid), 16'd0);

        out_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_5a");
`ifdef PARITY_ERR_CNT_EN
        chk("errcnt_after_5a", 16'(err_cnt), 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
